// File: rtl/shared_reg_arbiter_pkg.sv
// Shared constants, state type and index-width helper for the shared-register arbiter.
package shared_arb_pkg;

    localparam int unsigned N_REQ_DEF    = 4;
    localparam int unsigned DW_DEF       = 8;
    localparam int unsigned MAX_HOLD_DEF = 4;

    typedef enum logic [0:0] {
        StIdle,
        StOwned
    } own_st_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests, locks, data and grant/result.
interface shared_reg_arbiter_if
    import shared_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned DW    = DW_DEF
);

    localparam int unsigned IW = idx_w(N_REQ);

    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    lock;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    gnt;
    logic [DW-1:0]       q;
    logic                q_valid;
    logic [IW-1:0]       q_src;

    modport master (
        output req, lock, wdata,
        input  gnt, q, q_valid, q_src
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, q, q_valid, q_src
    );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req scanning from ptr upward, wrapping.
module rr_pick
    import shared_arb_pkg::*;
#(
    parameter int unsigned N = N_REQ_DEF
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [N-1:0]          win,
    output logic [idx_w(N)-1:0]   win_idx,
    output logic                  any
);

    localparam int unsigned IW = idx_w(N);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                win[idx] = 1'b1;
                win_idx  = IW'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a single registered word,
// with bounded burst locking.
module shared_reg_arbiter
    import shared_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = N_REQ_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shared_reg_arbiter_if.slave   bus
);

    localparam int unsigned IW = idx_w(N_REQ);
    localparam int unsigned HW = idx_w(MAX_HOLD);
    localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(N_REQ - 1);

    own_st_e          st_q, st_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [DW-1:0]    data_q, data_d;
    logic             valid_q, valid_d;
    logic [IW-1:0]    src_q, src_d;

    logic [N_REQ-1:0] pick_win;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    logic owner_req;
    logic owner_lock;
    logic keep;

    rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        src_d   = src_q;

        // gnt_q is always the one-hot of owner_q while owned, so the owner index selects the writer.
        owner_req  = (st_q == StOwned) && bus.req[owner_q];
        owner_lock = (st_q == StOwned) && bus.lock[owner_q];
        keep       = owner_req && owner_lock && (hold_q < HoldLast);

        if (owner_req) begin
            valid_d = 1'b1;
            src_d   = owner_q;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (owner_q == IW'(i)) begin
                    data_d = bus.wdata[i*DW +: DW];
                end
            end
        end

        if (keep) begin
            hold_d = hold_q + HW'(1);
        end else if (pick_any) begin
            st_d    = StOwned;
            owner_d = pick_idx;
            gnt_d   = pick_win;
            ptr_d   = (pick_idx == IdxLast) ? '0 : pick_idx + IW'(1);
            hold_d  = '0;
        end else begin
            st_d   = StIdle;
            gnt_d  = '0;
            hold_d = '0;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.q       = data_q;
    assign bus.q_valid = valid_q;
    assign bus.q_src   = src_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed steps plus randomized traffic
// against a behavioural arbitration model.
module tb_shared_reg_arbiter;
    import shared_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MH = 4;
    localparam int STARVE_BOUND = (N - 1) * MH + 1;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_mis;

    // Reference model state
    int          m_owner;
    int          m_ptr;
    int          m_ten;
    logic [N-1:0]  m_gnt;
    logic [DW-1:0] m_q;
    logic          m_qv;
    int            m_src;

    int wait_cnt [N];
    int max_wait;
    int srcs[$];
    logic [DW-1:0] q_prev;

    shared_reg_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

    shared_reg_arbiter #(
        .N_REQ    (N),
        .DW       (DW),
        .MAX_HOLD (MH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_ten   = 0;
        m_gnt   = '0;
        m_q     = '0;
        m_qv    = 1'b0;
        m_src   = 0;
    endtask

    // One clock edge of the arbitration rules, applied to sampled inputs.
    task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] l,
                              input logic [N*DW-1:0] wd);
        int w;
        bit wrote;
        wrote = (m_owner >= 0) && r[m_owner];
        m_qv  = wrote;
        if (wrote) begin
            m_q   = wd[m_owner*DW +: DW];
            m_src = m_owner;
        end
        if (wrote && l[m_owner] && (m_ten + 1 < MH)) begin
            m_ten++;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = (w + 1) % N;
                m_ten   = 0;
            end else begin
                m_owner = -1;
            end
        end
        m_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".gnt"},     64'(bus.gnt),     64'(m_gnt));
        check({tag, ".q"},       64'(bus.q),       64'(m_q));
        check({tag, ".q_valid"}, 64'(bus.q_valid), 64'(m_qv));
        check({tag, ".q_src"},   64'(bus.q_src),   64'(m_src));
        check({tag, ".onehot"},  64'($onehot0(bus.gnt)), 64'(1));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge(bus.req, bus.lock, bus.wdata);
        #1;
        check_outputs(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".gnt"},     64'(bus.gnt),     64'(0));
        check({tag, ".q"},       64'(bus.q),       64'(0));
        check({tag, ".q_valid"}, 64'(bus.q_valid), 64'(0));
        check({tag, ".q_src"},   64'(bus.q_src),   64'(0));
    endtask

    // Asserts reset between edges, checks the immediate clear, releases before the next edge.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_zero(tag);
        model_reset();
        #3 rst_n = 1'b1;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l);
        bus.req  = r;
        bus.lock = l;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        max_wait = 0;
        model_reset();

        // Reset held with active requests: everything stays zero.
        rst_n     = 1'b0;
        bus.req   = 4'b1111;
        bus.lock  = 4'b0000;
        bus.wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check_zero("rst_hold");
        end
        drive(4'b0000, 4'b0000);
        rst_n = 1'b1;
        cyc("idle0");
        cyc("idle1");

        // Single write by requester 2.
        bus.wdata = {8'h00, 8'hA5, 8'h00, 8'h00};
        drive(4'b0100, 4'b0000);
        cyc("single_gnt");
        check("single_gnt.exp", 64'(bus.gnt), 64'(4'b0100));
        cyc("single_wr");
        check("single_wr.q", 64'(bus.q), 64'(8'hA5));
        check("single_wr.src", 64'(bus.q_src), 64'(2));
        check("single_wr.qv", 64'(bus.q_valid), 64'(1));
        drive(4'b0000, 4'b0000);
        cyc("single_after0");
        cyc("single_after1");
        check("single_idle.gnt", 64'(bus.gnt), 64'(0));

        // Round-robin with all requesters, no lock.
        do_reset("rr_rst");
        bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        drive(4'b1111, 4'b0000);
        for (int k = 1; k <= 10; k++) begin
            cyc("rr");
            check("rr.gnt_order", 64'(bus.gnt), 64'(4'b0001 << ((k - 1) % 4)));
            if (k >= 2) begin
                check("rr.q_seq", 64'(bus.q), 64'(8'h10 + ((k - 2) % 4)));
                check("rr.one_per_cycle", 64'(bus.q_valid), 64'(1));
            end
        end

        // Locked burst from requester 0 bounded by MAX_HOLD, interleaved with requester 1.
        do_reset("lock_rst");
        bus.wdata = {8'h00, 8'h00, 8'hB1, 8'hB0};
        drive(4'b0011, 4'b0001);
        srcs.delete();
        for (int k = 0; k < 11; k++) begin
            cyc("lock");
            if (bus.q_valid) srcs.push_back(int'(bus.q_src));
        end
        begin
            int exp_src [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
            check("lock.nwrites", 64'(srcs.size()), 64'(10));
            for (int i = 0; i < 10 && i < srcs.size(); i++) begin
                check("lock.src_seq", 64'(srcs[i]), 64'(exp_src[i]));
            end
        end
        // Locked requester alone: re-granted at every expiry, writing every cycle.
        drive(4'b0001, 4'b0001);
        for (int k = 0; k < 9; k++) begin
            cyc("lock_alone");
            check("lock_alone.qv", 64'(bus.q_valid), 64'(1));
        end

        // One-cycle request held only through its grant cycle.
        do_reset("drop_rst");
        bus.wdata = {8'h00, 8'h00, 8'h5C, 8'h00};
        drive(4'b0010, 4'b0000);
        cyc("pulse_gnt");
        cyc("pulse_wr");
        check("pulse_wr.q", 64'(bus.q), 64'(8'h5C));
        drive(4'b0000, 4'b0000);
        cyc("pulse_waste");
        cyc("pulse_idle");
        // Request dropped before its grant arrives: wasted grant, no write.
        do_reset("waste_rst");
        bus.wdata = {8'h00, 8'h00, 8'h77, 8'h00};
        drive(4'b0010, 4'b0000);
        cyc("waste_gnt");
        q_prev = bus.q;
        drive(4'b0000, 4'b0000);
        cyc("waste_cyc");
        check("waste.qv", 64'(bus.q_valid), 64'(0));
        check("waste.q_hold", 64'(bus.q), 64'(q_prev));

        // Reset in the middle of a locked tenure, then restart from pointer 0.
        do_reset("mid_rst0");
        bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        drive(4'b1001, 4'b1001);
        cyc("burst0");
        cyc("burst1");
        cyc("burst2");
        do_reset("mid_burst");
        drive(4'b1111, 4'b0000);
        cyc("restart");
        check("restart.gnt", 64'(bus.gnt), 64'(4'b0001));

        // Unconstrained random traffic.
        for (int k = 0; k < 300; k++) begin
            bus.req   = N'($urandom);
            bus.lock  = N'($urandom);
            bus.wdata = (N*DW)'($urandom);
            cyc("rand");
        end

        // Requests held until accepted; also tracks worst-case grant wait.
        drive(4'b0000, 4'b0000);
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int k = 0; k < 400; k++) begin
            bus.wdata = (N*DW)'($urandom);
            bus.lock  = N'($urandom);
            cyc("held");
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && !bus.gnt[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                if (bus.req[i] && bus.q_valid && (int'(bus.q_src) == i)) bus.req[i] = 1'b0;
                else if (!bus.req[i] && ($urandom_range(0, 2) != 0)) bus.req[i] = 1'b1;
            end
        end
        check("starve_bound", 64'(max_wait <= STARVE_BOUND), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that gives N_REQ requesters write access to one shared, registered output word.
- Replaces designs where several always blocks drive the same register. Exactly one flop bank drives q, and one requester at a time owns the write port.
- Requesters may lock the grant for a burst. MAX_HOLD bounds a locked tenure so no requester starves.

Parameters:
- N_REQ, 4, number of requesters (>=1)
- DW, 8, data width of q and each wdata slice
- MAX_HOLD, 4, max accepted writes per locked tenure (>=1)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-requester write request; held until write accepted
- lock  in  N_REQ  per-requester burst lock, qualified by req
- wdata  in  N_REQ*DW  write data; slice i = wdata[i*DW +: DW]
- gnt  out  N_REQ  registered one-hot grant, all-zero when idle
- q  out  DW  shared registered word
- q_valid  out  1  one-cycle pulse: q updated at this edge
- q_src  out  clog2(N_REQ) (min 1)  index of requester that last wrote q

Behaviour:
- Reset (async, rst_n low): gnt=0, q=0, q_valid=0, q_src=0, rr pointer ptr=0, owner invalid, hold_cnt=0.
  - Reset mid-burst aborts the tenure immediately with no write.
  - First edge after release arbitrates from ptr=0.
- Write acceptance: at a posedge, if gnt[i]=1 and req[i]=1, then q<=wdata slice i, q_src<=i, q_valid<=1. Otherwise q and q_src hold and q_valid<=0.
- gnt[i]=1 with req[i]=0 means no write; the grant is dropped at that edge.
- Latency from an idle arbiter:
  - req[i] high in cycle 0.
  - gnt[i] high in cycle 1.
  - q and q_valid update at the end of cycle 1 (visible in cycle 2).
- Next-grant decision at every posedge, using the current owner o and sampled req/lock:
  - KEEP: if o valid, req[o]=1, lock[o]=1 and hold_cnt < MAX_HOLD-1, then gnt stays on o and hold_cnt increments.
  - ARB: otherwise pick the first asserted req scanning ptr, ptr+1, ... mod N_REQ.
    - gnt <= one-hot of the winner, owner <= winner, ptr <= (winner+1) mod N_REQ, hold_cnt <= 0.
    - If no req is asserted: gnt <= 0, owner invalid, ptr unchanged.
- The previous owner is eligible in ARB but has lowest priority, since ptr = o+1.
  - Locked owner alone at MAX_HOLD expiry: re-granted with a new tenure (hold_cnt=0).
  - Others waiting at expiry: forced rotation.
- Unlocked requester holding req continuously while alone gets a write every cycle.
- A requester that drops req after its accepted write may receive one wasted grant cycle. This is legal; no write occurs in that cycle.
- lock without req is ignored. lock changes mid-tenure take effect at the next edge.
- MAX_HOLD=1: lock has no effect; pure round-robin.
- N_REQ=1: gnt[0] follows req[0] with 1-cycle delay; q_src is constant 0.
- Invariants:
  - gnt is always one-hot or zero.
  - q changes only on edges with q_valid=1.
  - A requester with req held continuously waits at most (N_REQ-1)*MAX_HOLD + 1 cycles for a grant.
- Outputs gnt, q, q_valid and q_src are registered; there are no combinational input-to-output paths.

Decomposition:
- Package shared_arb_pkg:
  - default constants N_REQ_DEF=4, DW_DEF=8, MAX_HOLD_DEF=4
  - index-width function idx_w(n) = max(1, clog2(n))
- Sub-module rr_pick:
  - combinational, parameter N
  - inputs req[N] and ptr; outputs one-hot win[N], win_idx and any
  - Instantiated once for the ARB decision.
- All registers live in shared_reg_arbiter.

Test Plan:
- Reset/idle: hold rst_n=0 with req=4'b1111 and wdata nonzero -> gnt=0, q=0, q_valid=0 throughout. Release with req=0 -> outputs stay 0.
- Single write: req=4'b0100, wdata[2]=8'hA5 for one cycle after gnt -> gnt=4'b0100 in cycle 1, q=8'hA5, q_src=2, q_valid one pulse, then gnt=0.
- Round-robin fairness: req=4'b1111 held, lock=0, distinct data 8'h10..8'h13 -> grant order 0,1,2,3,0,...; q sequence 10,11,12,13,10,...; one write per cycle.
- Lock and expiry (MAX_HOLD=4):
  - req=4'b0011, lock=4'b0001 -> requester 0 gets exactly 4 consecutive writes, then gnt=4'b0010 for 1 write, then back to 0.
  - With req=4'b0001 only -> continuous writes, tenure restarts every 4.
- Req drop and wasted grant: req[1] pulsed for 1 cycle at gnt -> one write. If req[1] drops the cycle before gnt arrives -> gnt[1] high one cycle, no q_valid, q unchanged.
- Reset mid-burst: assert rst_n low asynchronously (between edges) during a locked tenure -> gnt, q, q_valid and q_src go to 0 immediately. After release, arbitration restarts at ptr=0.
